ex_mem_stage_reg: RTL and testbench

Parametrised EX/MEM pipeline register with a valid/ready handshake, a 2-entry skid buffer, flush and stall accounting. It sits between the Execute stage and the memory stage and carries the WB/MEM control fields, destination register, ALU result and store data. It is the drop-in successor to the fixed-width EX/MEM latch. It adds bubbles, back-pressure and squash that the plain latch cannot express.

---
 rtl/ex_mem_stage_reg.sv | 126 ++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, flush squash and a saturating output-stall counter.
module ex_mem_stage_reg #(
  parameter int WB_W   = 2,
  parameter int MEM_W  = 3,
  parameter int RD_W   = 5,
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB_in,
  input  logic [MEM_W-1:0]  MEM_in,
  input  logic [RD_W-1:0]   RD_in,
  input  logic [DATA_W-1:0] ALU_in,
  input  logic [DATA_W-1:0] WriteData_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   WB_out,
  output logic [MEM_W-1:0]  MEM_out,
  output logic [RD_W-1:0]   RD_out,
  output logic [DATA_W-1:0] ALU_out,
  output logic [DATA_W-1:0] WriteData_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int  ENT_W    = WB_W + MEM_W + RD_W + 2 * DATA_W;
  localparam bit  USE_SKID = (SKID != 32'sd0);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_r;
  logic [ENT_W-1:0]   main_r;
  logic [ENT_W-1:0]   skid_r;
  logic [ENT_W-1:0]   entry_s;
  logic               out_valid_r;
  logic               in_ready_r;
  logic               accept_s;
  logic               drain_s;
  logic [CNT_W-1:0]   stall_cnt_r;

  assign entry_s = {WB_in, MEM_in, RD_in, ALU_in, WriteData_in};

  // Without a skid buffer in_ready_r only marks "out of reset"; readiness then
  // follows the downstream handshake combinationally.
  assign in_ready = USE_SKID ? in_ready_r
                             : (in_ready_r & (~out_valid_r | out_ready));

  assign accept_s = in_valid & in_ready & ~flush;
  assign drain_s  = out_valid_r & out_ready;

  // Occupancy FSM: main register feeds the outputs, skid holds the late entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      main_r      <= '0;
      skid_r      <= '0;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      main_r      <= '0;
      skid_r      <= '0;
    end else begin
      in_ready_r <= 1'b1;
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
            main_r      <= entry_s;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            main_r <= entry_s;
          end else if (accept_s) begin
            // Only reachable with the skid buffer: in_ready was still high.
            state_r    <= ST_TWO;
            skid_r     <= entry_s;
            in_ready_r <= 1'b0;
          end else if (drain_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        ST_TWO: begin
          if (drain_s) begin
            state_r <= ST_ONE;
            main_r  <= skid_r;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles the output is held by downstream back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = out_valid_r;
  assign stall_cnt = stall_cnt_r;
  assign {WB_out, MEM_out, RD_out, ALU_out, WriteData_out} = main_r;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg: skid, no-skid and narrow-counter instances.
module tb_ex_mem_stage_reg;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]  wb_i;
  logic [2:0]  mem_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_i;
  logic [31:0] wd_i;

  logic iv1, or1, fl1, ir1, ov1;
  logic [1:0] wb1; logic [2:0] mem1; logic [4:0] rd1; logic [31:0] alu1, wd1; logic [15:0] sc1;
  logic iv0, or0, fl0, ir0, ov0;
  logic [1:0] wb0; logic [2:0] mem0; logic [4:0] rd0; logic [31:0] alu0, wd0; logic [15:0] sc0;
  logic iv4, or4, fl4, ir4, ov4;
  logic [1:0] wb4; logic [2:0] mem4; logic [4:0] rd4; logic [31:0] alu4, wd4; logic [3:0] sc4;

  int total = 0;
  int bad   = 0;

  logic [7:0] t_or = 8'b1010_1010;
  logic [7:0] t_iv = 8'b0011_1111;
  logic [7:0] t_ir = 8'b1010_1011;
  logic [7:0] t_ov = 8'b0111_1111;
  logic [31:0] t_in  [8] = '{32'h30, 32'h31, 32'h32, 32'h32, 32'h33, 32'h33, 32'h00, 32'h00};
  logic [31:0] t_out [8] = '{32'h30, 32'h31, 32'h31, 32'h32, 32'h32, 32'h33, 32'h33, 32'h33};

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.SKID(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .WB_in(wb_i), .MEM_in(mem_i), .RD_in(rd_i), .ALU_in(alu_i), .WriteData_in(wd_i),
    .out_valid(ov1), .out_ready(or1), .WB_out(wb1), .MEM_out(mem1), .RD_out(rd1),
    .ALU_out(alu1), .WriteData_out(wd1), .stall_cnt(sc1));

  ex_mem_stage_reg #(.SKID(0)) u_s0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
    .WB_in(wb_i), .MEM_in(mem_i), .RD_in(rd_i), .ALU_in(alu_i), .WriteData_in(wd_i),
    .out_valid(ov0), .out_ready(or0), .WB_out(wb0), .MEM_out(mem0), .RD_out(rd0),
    .ALU_out(alu0), .WriteData_out(wd0), .stall_cnt(sc0));

  ex_mem_stage_reg #(.SKID(1), .CNT_W(4)) u_s4 (
    .clk(clk), .rst(rst), .flush(fl4), .in_valid(iv4), .in_ready(ir4),
    .WB_in(wb_i), .MEM_in(mem_i), .RD_in(rd_i), .ALU_in(alu_i), .WriteData_in(wd_i),
    .out_valid(ov4), .out_ready(or4), .WB_out(wb4), .MEM_out(mem4), .RD_out(rd4),
    .ALU_out(alu4), .WriteData_out(wd4), .stall_cnt(sc4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // reset with random inputs
    rst = 1'b1;
    wb_i = 2'($urandom); mem_i = 3'($urandom); rd_i = 5'($urandom);
    alu_i = $urandom; wd_i = $urandom;
    iv1 = 1'b1; or1 = 1'b0; fl1 = 1'b0;
    iv0 = 1'b1; or0 = 1'b1; fl0 = 1'b0;
    iv4 = 1'b1; or4 = 1'b0; fl4 = 1'b0;
    tick(); tick();
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_ir1", 64'(ir1), 64'd0);
    chk("rst_alu1", 64'(alu1), 64'd0);
    chk("rst_wd1", 64'(wd1), 64'd0);
    chk("rst_wb_mem_rd1", 64'({wb1, mem1, rd1}), 64'd0);
    chk("rst_sc1", 64'(sc1), 64'd0);
    chk("rst_ir0", 64'(ir0), 64'd0);
    chk("rst_ov0", 64'(ov0), 64'd0);
    chk("rst_ir4", 64'(ir4), 64'd0);

    rst = 1'b0;
    iv1 = 1'b0; iv0 = 1'b0; iv4 = 1'b0;
    or1 = 1'b1; or0 = 1'b0;
    tick();
    chk("rel_ir1", 64'(ir1), 64'd1);
    chk("rel_ov1", 64'(ov1), 64'd0);
    chk("rel_ir0", 64'(ir0), 64'd1);

    // streaming, SKID=1
    wb_i = 2'd1; mem_i = 3'd5; wd_i = 32'hCAFE0000;
    for (int i = 0; i < 8; i++) begin
      alu_i = 32'h10 + 32'(i);
      rd_i  = 5'(i);
      iv1   = 1'b1;
      tick();
      chk("str_ov", 64'(ov1), 64'd1);
      chk("str_alu", 64'(alu1), 64'(32'h10 + 32'(i)));
    end
    chk("str_rd_last", 64'(rd1), 64'd7);
    chk("str_wd", 64'(wd1), 64'hCAFE0000);
    iv1 = 1'b0;
    tick();
    chk("str_ov_end", 64'(ov1), 64'd0);
    chk("str_sc", 64'(sc1), 64'd0);

    // back-pressure, SKID=1
    iv1 = 1'b1; alu_i = 32'hA; or1 = 1'b1;
    tick();
    chk("bp_a_out", 64'(alu1), 64'hA);
    or1 = 1'b0; alu_i = 32'hB;
    tick();
    chk("bp_ir_low", 64'(ir1), 64'd0);
    chk("bp_a_hold1", 64'(alu1), 64'hA);
    alu_i = 32'hC;
    tick();
    chk("bp_a_hold2", 64'(alu1), 64'hA);
    chk("bp_ir_low2", 64'(ir1), 64'd0);
    tick();
    chk("bp_a_hold3", 64'(alu1), 64'hA);
    chk("bp_sc3", 64'(sc1), 64'd3);
    or1 = 1'b1;
    tick();
    chk("bp_b_out", 64'(alu1), 64'hB);
    chk("bp_b_ov", 64'(ov1), 64'd1);
    chk("bp_ir_back", 64'(ir1), 64'd1);
    tick();
    chk("bp_c_out", 64'(alu1), 64'hC);
    iv1 = 1'b0;
    tick();
    chk("bp_empty", 64'(ov1), 64'd0);
    chk("bp_sc_final", 64'(sc1), 64'd3);

    // flush in state TWO with in_valid=1
    or1 = 1'b0; iv1 = 1'b1; alu_i = 32'h21; wd_i = 32'h12345678;
    tick();
    alu_i = 32'h22;
    tick();
    chk("fl_two_ir", 64'(ir1), 64'd0);
    fl1 = 1'b1; alu_i = 32'h23;
    tick();
    chk("fl_ov", 64'(ov1), 64'd0);
    chk("fl_alu", 64'(alu1), 64'd0);
    chk("fl_wd", 64'(wd1), 64'd0);
    chk("fl_wb_mem_rd", 64'({wb1, mem1, rd1}), 64'd0);
    chk("fl_ir", 64'(ir1), 64'd1);
    chk("fl_sc", 64'(sc1), 64'd5);
    fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    tick();
    chk("fl_no_ghost1", 64'(ov1), 64'd0);
    tick();
    chk("fl_no_ghost2", 64'(ov1), 64'd0);
    iv1 = 1'b1; alu_i = 32'h24;
    tick();
    chk("fl_recover", 64'(alu1), 64'h24);
    iv1 = 1'b0;
    tick();
    chk("fl_recover_ov", 64'(ov1), 64'd0);

    // SKID=0 with out_ready toggling
    for (int k = 0; k < 8; k++) begin
      or0 = t_or[k]; iv0 = t_iv[k]; alu_i = t_in[k];
      #1;
      chk("s0_ir", 64'(ir0), 64'(t_ir[k]));
      tick();
      chk("s0_ov", 64'(ov0), 64'(t_ov[k]));
      chk("s0_alu", 64'(alu0), 64'(t_out[k]));
    end

    // stall counter saturation, CNT_W=4
    iv4 = 1'b1; or4 = 1'b0; alu_i = 32'h40;
    tick();
    iv4 = 1'b0;
    repeat (14) tick();
    chk("sat_14", 64'(sc4), 64'd14);
    repeat (6) tick();
    chk("sat_15", 64'(sc4), 64'd15);
    chk("sat_ov", 64'(ov4), 64'd1);
    tick();
    chk("sat_stay", 64'(sc4), 64'd15);
    fl4 = 1'b1;
    tick();
    chk("sat_flush_ov", 64'(ov4), 64'd0);
    chk("sat_flush_sc", 64'(sc4), 64'd15);
    fl4 = 1'b0;
    tick();
    chk("sat_after_flush", 64'(sc4), 64'd15);

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("arst_sc4", 64'(sc4), 64'd0);
    chk("arst_sc1", 64'(sc1), 64'd0);
    chk("arst_alu1", 64'(alu1), 64'd0);
    chk("arst_alu0", 64'(alu0), 64'd0);
    chk("arst_ir1", 64'(ir1), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_rel_ir1", 64'(ir1), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
